// File: rtl/gpt_pkg.sv
// Shared types and helpers for the general-purpose timer input-capture channel.
package gpt_pkg;

    localparam int ICF_W = 4;

    typedef enum logic [1:0] {
        ICPS_DIV1 = 2'b00,
        ICPS_DIV2 = 2'b01,
        ICPS_DIV4 = 2'b10,
        ICPS_DIV8 = 2'b11
    } icps_t;

    typedef enum logic [1:0] {
        CCP_RISE = 2'b00,
        CCP_FALL = 2'b01,
        CCP_RSVD = 2'b10,
        CCP_BOTH = 2'b11
    } ccp_t;

    // Terminal value of the edge prescaler count (divide ratio minus one).
    function automatic logic [2:0] presc_div(input icps_t icps);
        case (icps)
            ICPS_DIV1: presc_div = 3'd0;
            ICPS_DIV2: presc_div = 3'd1;
            ICPS_DIV4: presc_div = 3'd3;
            default:   presc_div = 3'd7;
        endcase
    endfunction

endpackage

// File: rtl/ic_filter.sv
// Capture pin front end: 2-FF synchroniser, consecutive-sample digital filter
// and edge detector on the filtered level.
module ic_filter
    import gpt_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             ic_i,
    input  logic [ICF_W-1:0] icf_i,
    output logic             rise_o,
    output logic             fall_o
);

    logic             sync_p0;
    logic             sync_p1;
    logic             filt_q;
    logic             prev_q;
    logic             level;
    logic [ICF_W-1:0] flt_cnt;

    // With the filter bypassed the synchroniser output drives the level directly,
    // while filt_q keeps tracking it so enabling the filter later starts clean.
    assign level  = (icf_i == '0) ? sync_p1 : filt_q;
    assign rise_o = level & ~prev_q;
    assign fall_o = ~level & prev_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            filt_q  <= 1'b0;
            prev_q  <= 1'b0;
            flt_cnt <= '0;
        end else begin
            // stage p0 -> p1: metastability hardening
            sync_p0 <= ic_i;
            sync_p1 <= sync_p0;
            prev_q  <= level;
            if (icf_i == '0) begin
                filt_q  <= sync_p1;
                flt_cnt <= '0;
            end else if (sync_p1 == filt_q) begin
                flt_cnt <= '0;
            end else if (flt_cnt + ICF_W'(1) == icf_i) begin
                filt_q  <= sync_p1;
                flt_cnt <= '0;
            end else begin
                flt_cnt <= flt_cnt + ICF_W'(1);
            end
        end
    end

endmodule

// File: rtl/input_capture_ctrl.sv
// One timer input-capture channel: edge select, 1/2/4/8 prescaler, capture
// register and capture/overcapture flags.
module input_capture_ctrl
    import gpt_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             cce_i,
    input  logic             ic_i,
    input  logic [1:0]       icps_i,
    input  logic [ICF_W-1:0] icf_i,
    input  logic [1:0]       ccp_i,
    input  logic [CNT_W-1:0] cnt_i,
    input  logic             ccif_clr_i,
    input  logic             ccof_clr_i,
    output logic [CNT_W-1:0] ccr_o,
    output logic             ccif_o,
    output logic             ccof_o,
    output logic             cap_evt_o
);

    icps_t      icps;
    icps_t      icps_q;
    ccp_t       ccp;
    logic       rise;
    logic       fall;
    logic       edge_qual;
    logic       icps_chg;
    logic       cap_vld_p0;
    logic [2:0] presc_cnt;

    assign icps = icps_t'(icps_i);
    assign ccp  = ccp_t'(ccp_i);

    ic_filter u_ic_filter (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .ic_i   (ic_i),
        .icf_i  (icf_i),
        .rise_o (rise),
        .fall_o (fall)
    );

    always_comb begin
        edge_qual = rise;
        case (ccp)
            CCP_FALL: edge_qual = fall;
            CCP_BOTH: edge_qual = rise | fall;
            default:  edge_qual = rise;
        endcase
    end

    // A prescaler reprogramming restarts the edge count and suppresses capture.
    assign icps_chg   = (icps != icps_q);
    assign cap_vld_p0 = cce_i && !icps_chg && edge_qual && (presc_cnt == presc_div(icps));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            icps_q    <= icps;
            presc_cnt <= '0;
            ccr_o     <= '0;
            ccif_o    <= 1'b0;
            ccof_o    <= 1'b0;
            cap_evt_o <= 1'b0;
        end else begin
            icps_q <= icps;
            if (!cce_i || icps_chg) begin
                presc_cnt <= '0;
            end else if (edge_qual) begin
                presc_cnt <= cap_vld_p0 ? 3'd0 : presc_cnt + 3'd1;
            end
            // stage p0 -> outputs: capture register and flags
            cap_evt_o <= cap_vld_p0;
            if (cap_vld_p0) begin
                ccr_o <= cnt_i;
            end
            ccif_o <= cap_vld_p0 | (ccif_o & ~ccif_clr_i);
            ccof_o <= (cap_vld_p0 & ccif_o) | (ccof_o & ~ccof_clr_i);
        end
    end

endmodule

// File: tb/tb_input_capture_ctrl.sv
// Scoreboard bench for input_capture_ctrl: directed phases plus randomized traffic
// checked against a sample-history reference model.
module tb_input_capture_ctrl;

    localparam int CNT_W = 16;
    localparam int MAXC  = 8192;

    logic             clk = 1'b0;
    logic             rst_i = 1'b1;
    logic             cce_i = 1'b0;
    logic             ic_i = 1'b0;
    logic [1:0]       icps_i = 2'b00;
    logic [3:0]       icf_i = 4'd0;
    logic [1:0]       ccp_i = 2'b00;
    logic [CNT_W-1:0] cnt_i = '0;
    logic             ccif_clr_i = 1'b0;
    logic             ccof_clr_i = 1'b0;
    logic [CNT_W-1:0] ccr_o;
    logic             ccif_o;
    logic             ccof_o;
    logic             cap_evt_o;

    always #5 clk = ~clk;

    input_capture_ctrl #(.CNT_W(CNT_W)) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .cce_i      (cce_i),
        .ic_i       (ic_i),
        .icps_i     (icps_i),
        .icf_i      (icf_i),
        .ccp_i      (ccp_i),
        .cnt_i      (cnt_i),
        .ccif_clr_i (ccif_clr_i),
        .ccof_clr_i (ccof_clr_i),
        .ccr_o      (ccr_o),
        .ccif_o     (ccif_o),
        .ccof_o     (ccof_o),
        .cap_evt_o  (cap_evt_o)
    );

    typedef struct packed {
        logic             evt;
        logic [CNT_W-1:0] ccr;
        logic             ccif;
        logic             ccof;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   dut_caps = 0;
    int   mdl_caps = 0;
    int   cyc      = 0;

    // stimulus variables applied at the next tick
    logic             v_rst = 1'b1, v_cce = 1'b1, v_ic = 1'b0;
    logic             v_ccif_clr = 1'b0, v_ccof_clr = 1'b0;
    logic [1:0]       v_icps = 2'b00, v_ccp = 2'b00;
    logic [3:0]       v_icf = 4'd0;
    logic [CNT_W-1:0] v_cnt = 16'h1000;
    bit               rand_cnt = 1'b0;

    // reference model: pin sample per edge and filtered level after each edge
    bit               hist [0:MAXC-1];
    bit               filt [0:MAXC-1];
    int               k = 2;
    int               rst_edge = 2;
    bit               pend = 1'b0;
    int               m_edges = 0;
    logic [1:0]       last_icps = 2'b00;
    bit               m_ccif = 1'b0, m_ccof = 1'b0;
    logic [CNT_W-1:0] m_ccr = '0;

    task automatic model_edge();
        exp_t e;
        bit   chg, qual, cap, run;
        int   div;
        cap = 1'b0;
        if (v_rst) begin
            hist[k] = 1'b0; hist[k-1] = 1'b0;
            filt[k] = 1'b0; filt[k-1] = 1'b0;
            rst_edge = k; pend = 1'b0; m_edges = 0; last_icps = v_icps;
            m_ccif = 1'b0; m_ccof = 1'b0; m_ccr = '0;
        end else begin
            chg = (v_icps != last_icps);
            last_icps = v_icps;
            if (v_ccp == 2'b01)      qual = pend && !filt[k-1];
            else if (v_ccp == 2'b11) qual = pend;
            else                     qual = pend && filt[k-1];
            div = 1 << v_icps;
            if (!v_cce || chg) begin
                m_edges = 0;
            end else if (qual) begin
                if (m_edges == div - 1) begin
                    cap = 1'b1;
                    m_edges = 0;
                end else begin
                    m_edges++;
                end
            end
            if (cap && m_ccif) m_ccof = 1'b1;
            else if (v_ccof_clr) m_ccof = 1'b0;
            if (cap) m_ccif = 1'b1;
            else if (v_ccif_clr) m_ccif = 1'b0;
            if (cap) begin
                m_ccr = v_cnt;
                mdl_caps++;
            end
            hist[k] = v_ic;
            // filtered level flips once the last icf samples all disagree with it
            if (v_icf == 4'd0) begin
                filt[k] = hist[k-1];
            end else begin
                filt[k] = filt[k-1];
                if (k - 1 - int'(v_icf) >= rst_edge - 1) begin
                    run = 1'b1;
                    for (int j = k - 1 - int'(v_icf); j <= k - 2; j++)
                        if (hist[j] == filt[k-1]) run = 1'b0;
                    if (run) filt[k] = ~filt[k-1];
                end
            end
            pend = (filt[k] != filt[k-1]);
        end
        e.evt  = cap;
        e.ccr  = m_ccr;
        e.ccif = m_ccif;
        e.ccof = m_ccof;
        exp_q.push_back(e);
        k++;
    endtask

    task automatic tick();
        @(negedge clk);
        rst_i      = v_rst;
        cce_i      = v_cce;
        ic_i       = v_ic;
        icps_i     = v_icps;
        icf_i      = v_icf;
        ccp_i      = v_ccp;
        cnt_i      = v_cnt;
        ccif_clr_i = v_ccif_clr;
        ccof_clr_i = v_ccof_clr;
        model_edge();
        v_ccif_clr = 1'b0;
        v_ccof_clr = 1'b0;
        if (!rand_cnt) v_cnt = v_cnt + 16'd1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse(input int hi, input int lo);
        v_ic = 1'b1; idle(hi);
        v_ic = 1'b0; idle(lo);
    endtask

    task automatic check_caps(input string name, input int base, input int exp_n);
        @(posedge clk);
        #2;
        n_checks++;
        if (dut_caps - base == exp_n) n_pass++;
        else $display("FAIL %s: captures got %0d, expected %0d", name, dut_caps - base, exp_n);
    endtask

    // monitor: one expected output record per clock edge
    always begin
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (cap_evt_o) dut_caps++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (cap_evt_o === e.evt && ccr_o === e.ccr && ccif_o === e.ccif && ccof_o === e.ccof)
                n_pass++;
            else
                $display("FAIL %s cyc %0d: got evt=%0b ccr=%h ccif=%0b ccof=%0b, expected evt=%0b ccr=%h ccif=%0b ccof=%0b",
                         (e.evt || cap_evt_o) ? "capture" : "idle", cyc, cap_evt_o, ccr_o, ccif_o, ccof_o,
                         e.evt, e.ccr, e.ccif, e.ccof);
        end
    end

    initial begin
        int base;
        int hold;
        // reset, then rising-edge captures at /1
        v_rst = 1'b1; idle(3);
        v_rst = 1'b0; idle(4);
        base = dut_caps;
        for (int i = 0; i < 3; i++) pulse(4, 4);
        idle(4);
        check_caps("rise_div1", base, 3);

        // both edges at /8: 16 toggles give two captures
        v_icps = 2'b11; v_ccp = 2'b11; idle(4);
        base = dut_caps;
        for (int i = 0; i < 16; i++) begin
            v_ic = ~v_ic; idle(3);
        end
        idle(4);
        check_caps("both_div8", base, 2);

        // filter of 4: short glitch rejected, longer pulse captured
        v_icps = 2'b00; v_ccp = 2'b00; v_icf = 4'd4; idle(4);
        base = dut_caps;
        pulse(3, 10);
        check_caps("glitch", base, 0);
        pulse(6, 12);
        check_caps("filtered_pulse", base, 1);

        // flag clear interactions
        v_icf = 4'd0; idle(2);
        v_ccif_clr = 1'b1; v_ccof_clr = 1'b1; idle(3);
        pulse(4, 4);
        v_ic = 1'b1; idle(2);
        v_ccif_clr = 1'b1; idle(3);
        v_ic = 1'b0; idle(3);
        v_ccif_clr = 1'b1; idle(3);

        // prescaler reprogramming and channel disable
        v_icps = 2'b01; idle(3);
        base = dut_caps;
        pulse(3, 4);
        v_icps = 2'b10; idle(2);
        for (int i = 0; i < 4; i++) pulse(3, 4);
        idle(3);
        check_caps("icps_change", base, 1);
        base = dut_caps;
        v_cce = 1'b0;
        for (int i = 0; i < 3; i++) pulse(3, 4);
        idle(3);
        check_caps("cce_off", base, 0);
        v_cce = 1'b1; idle(2);

        // reset between prescaled edges restarts the count
        v_icps = 2'b01; idle(3);
        pulse(3, 4);
        v_rst = 1'b1; idle(2);
        v_rst = 1'b0; idle(2);
        base = dut_caps;
        pulse(3, 5);
        check_caps("after_reset_1st", base, 0);
        pulse(3, 5);
        check_caps("after_reset_2nd", base, 1);

        // randomized traffic
        rand_cnt = 1'b1;
        hold = 0;
        for (int c = 0; c < 3000; c++) begin
            if (hold == 0) begin
                v_ic = ~v_ic;
                hold = $urandom_range(1, 12);
            end
            hold--;
            v_ccif_clr = ($urandom_range(0, 15) == 0);
            v_ccof_clr = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 199) == 0) v_icps = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 199) == 0) v_ccp = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 149) == 0) v_cce = ($urandom_range(0, 4) != 0);
            v_rst = ($urandom_range(0, 399) == 0);
            if (v_rst) v_icf = 4'($urandom_range(0, 6));
            v_cnt = 16'($urandom);
            tick();
        end
        v_rst = 1'b0; idle(12);
        @(posedge clk);
        #2;
        n_checks++;
        if (dut_caps == mdl_caps) n_pass++;
        else $display("FAIL total_caps: got %0d, expected %0d", dut_caps, mdl_caps);
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain: %0d records left, expected 0", exp_q.size());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
